// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, FSM state codes and the byte-strobe helper
// used by the register responder and its register bank.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  // Control captured in the address phase and consumed in the data phase.
  typedef struct packed {
    logic       write;
    logic [3:0] strb;
  } xfer_ctl_t;

  function automatic logic [3:0] byte_strobe(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: return 4'b0001 << addr_lo;
      HSIZE_HALF: return 4'b0011 << addr_lo;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_reg_bank.sv
// Register array with a byte-strobed write port and a combinational read
// port that forwards a same-cycle committing write.
module ahb_reg_bank
  import ahb_pkg::*;
#(
  parameter int REG_NUM = 8,
  parameter int IDX_W   = 3
) (
  input  logic                   HCLK,
  input  logic                   H_REST,
  input  logic                   we,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [3:0]             wr_strb,
  input  logic [31:0]            wr_data,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [31:0]            rd_data,
  output logic [32*REG_NUM-1:0]  reg_out
);

  logic [31:0] regs [REG_NUM];

  // NOTE: these are control registers that peripherals act on straight out of
  // reset, so the array is reset like ordinary flops rather than left as RAM.
  always_ff @(posedge HCLK or posedge H_REST) begin
    if (H_REST) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  // A read sampled on the same edge a write commits sees the merged word.
  always_comb begin
    rd_data = regs[rd_idx];
    if (we && (wr_idx == rd_idx))
      for (int b = 0; b < 4; b++)
        if (wr_strb[b]) rd_data[8*b +: 8] = wr_data[8*b +: 8];
  end

  for (genvar k = 0; k < REG_NUM; k++) begin : g_out
    assign reg_out[32*k +: 32] = regs[k];
  end

endmodule

// File: rtl/ahb_reg_slave.sv
// AHB-Lite register responder: decode, wait-state FSM and ERROR handling.
// Define AHB_REG_SLAVE_PROT_EN to reject user-mode writes to register 0.
module ahb_reg_slave
  import ahb_pkg::*;
#(
  parameter int REG_NUM            = 8,
  parameter int WAIT_CYCLES        = 0,
  parameter int C_S_AHB_DATA_WIDTH = 32,
  parameter int C_S_AHB_ADDR_WIDTH = 32
) (
  input  logic                          HCLK,
  input  logic                          H_REST,
  input  logic                          HSEL,
  input  logic [C_S_AHB_ADDR_WIDTH-1:0] S_HADDR,
  input  logic [1:0]                    S_HTRANS,
  input  logic [2:0]                    S_HBURST,
  input  logic [2:0]                    S_HSIZE,
  input  logic [3:0]                    S_HPORT,
  input  logic                          S_HWRITE,
  input  logic [31:0]                   S_HWDATA,
  output logic [31:0]                   HRDATA,
  output logic [1:0]                    HRESP,
  output logic                          HREADY_o,
  output logic [32*REG_NUM-1:0]         REG_OUT
);

  localparam int         IDX_W     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int         OFF_W     = C_S_AHB_ADDR_WIDTH - 2;
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [2:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, rd_idx;
  xfer_ctl_t        ctl_q;
  logic [OFF_W-1:0] word_off;
  logic             accept, bad, bad_prot, load_rd, commit;
  logic [31:0]      rd_data;
  logic             unused_bits;

  assign word_off = S_HADDR[C_S_AHB_ADDR_WIDTH-1:2];
  assign accept   = HSEL && S_HTRANS[1] && HREADY_o;

`ifdef AHB_REG_SLAVE_PROT_EN
  assign bad_prot = S_HWRITE && !S_HPORT[1] && (word_off == '0);
`else
  assign bad_prot = 1'b0;
`endif

  assign bad = (word_off >= OFF_W'(REG_NUM)) || (S_HSIZE > HSIZE_WORD)
            || ((S_HSIZE == HSIZE_HALF) && S_HADDR[0])
            || ((S_HSIZE == HSIZE_WORD) && (S_HADDR[1:0] != 2'b00))
            || bad_prot;

  // Burst type is irrelevant: every beat is decoded on its own.
  assign unused_bits = ^{S_HBURST, S_HPORT};

  assign HREADY_o = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign HRESP    = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign commit   = (state_q == ST_DATA) && ctl_q.write;
  assign rd_idx   = (state_q == ST_WAIT) ? idx_q : word_off[IDX_W-1:0];

  // NOTE: every output of this block gets a default first so that no path
  // through the case leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_rd = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          load_rd = !ctl_q.write;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (!accept)               state_d = ST_IDLE;
        else if (bad)              state_d = ST_ERR1;
        else if (WAIT_CYCLES > 0)  state_d = ST_WAIT;
        else begin
          state_d = ST_DATA;
          load_rd = !S_HWRITE;
        end
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees
  // the pre-edge values, and the reset is asynchronous so a transfer in
  // flight is abandoned immediately.
  always_ff @(posedge HCLK or posedge H_REST) begin
    if (H_REST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ctl_q   <= '0;
      HRDATA  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q <= word_off[IDX_W-1:0];
        ctl_q <= '{write: S_HWRITE, strb: byte_strobe(S_HSIZE, S_HADDR[1:0])};
      end
      if (load_rd) HRDATA <= rd_data;
    end
  end

  ahb_reg_bank #(
    .REG_NUM (REG_NUM),
    .IDX_W   (IDX_W)
  ) u_bank (
    .HCLK    (HCLK),
    .H_REST  (H_REST),
    .we      (commit),
    .wr_idx  (idx_q),
    .wr_strb (ctl_q.strb),
    .wr_data (S_HWDATA),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .reg_out (REG_OUT)
  );

endmodule

// File: tb/tb_ahb_reg_slave.sv
// Directed bench for ahb_reg_slave: a zero-wait instance driven from a
// per-cycle vector table and a three-wait instance driven by hand sequences.
module tb_ahb_reg_slave;

  localparam logic [1:0] ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
  localparam logic [1:0] OK = 2'b00, ER = 2'b01;
  localparam logic [3:0] P1 = 4'b0001, P3 = 4'b0011;
`ifdef AHB_REG_SLAVE_PROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        HCLK, H_REST;
  logic        sel0, sel3;
  logic [31:0] S_HADDR, S_HWDATA;
  logic [1:0]  S_HTRANS;
  logic [2:0]  S_HBURST, S_HSIZE;
  logic [3:0]  S_HPORT;
  logic        S_HWRITE;

  logic [31:0]  HRDATA0, HRDATA3;
  logic [1:0]   HRESP0, HRESP3;
  logic         HREADY0, HREADY3;
  logic [255:0] REG_OUT0, REG_OUT3;

  int checks = 0;
  int failures = 0;

  ahb_reg_slave #(.REG_NUM(8), .WAIT_CYCLES(0)) dut0 (
    .HCLK(HCLK), .H_REST(H_REST), .HSEL(sel0), .S_HADDR(S_HADDR),
    .S_HTRANS(S_HTRANS), .S_HBURST(S_HBURST), .S_HSIZE(S_HSIZE),
    .S_HPORT(S_HPORT), .S_HWRITE(S_HWRITE), .S_HWDATA(S_HWDATA),
    .HRDATA(HRDATA0), .HRESP(HRESP0), .HREADY_o(HREADY0), .REG_OUT(REG_OUT0));

  ahb_reg_slave #(.REG_NUM(8), .WAIT_CYCLES(3)) dut3 (
    .HCLK(HCLK), .H_REST(H_REST), .HSEL(sel3), .S_HADDR(S_HADDR),
    .S_HTRANS(S_HTRANS), .S_HBURST(S_HBURST), .S_HSIZE(S_HSIZE),
    .S_HPORT(S_HPORT), .S_HWRITE(S_HWRITE), .S_HWDATA(S_HWDATA),
    .HRDATA(HRDATA3), .HRESP(HRESP3), .HREADY_o(HREADY3), .REG_OUT(REG_OUT3));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [15:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  port;
    logic        exp_rdy;
    logic [1:0]  exp_resp;
    bit          chk_rd;
    logic [31:0] exp_rd;
    int          reg_idx;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic sel, input logic [1:0] tr, input logic [15:0] a,
                              input logic [2:0] sz, input logic wr, input logic [31:0] wd,
                              input logic [3:0] pt, input logic rdy, input logic [1:0] rsp,
                              input bit crd, input logic [31:0] rd, input int ri,
                              input logic [31:0] rv);
    vec_t v;
    v = '{sel, tr, a, sz, wr, wd, pt, rdy, rsp, crd, rd, ri, rv};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts HREADY-low cycles of the three-wait instance, bounded at 16.
  task automatic count_wait(output int n);
    n = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge HCLK);
      S_HTRANS = ID;
      #1;
      if (HREADY3 === 1'b1) break;
      n++;
    end
  endtask

  initial begin
    int n;
    H_REST = 1'b1; sel0 = 1'b0; sel3 = 1'b0; S_HADDR = '0; S_HWDATA = '0;
    S_HTRANS = ID; S_HBURST = '0; S_HSIZE = SW; S_HPORT = P3; S_HWRITE = 1'b0;

    // Each row is one clock cycle; HWDATA belongs to the previous row's address.
    vecs.push_back(mk(1, NS, 16'h04, SW, 1, 32'h0,        P3, 1, OK, 0, 0,            -1, 0));
    vecs.push_back(mk(1, NS, 16'h04, SW, 0, 32'hDEADBEEF, P3, 1, OK, 0, 0,            -1, 0));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'h0,        P3, 1, OK, 1, 32'hDEADBEEF,  1, 32'hDEADBEEF));
    vecs.push_back(mk(1, NS, 16'h04, SW, 1, 32'h0,        P3, 1, OK, 0, 0,            -1, 0));
    vecs.push_back(mk(1, NS, 16'h06, SB, 1, 32'h11223344, P3, 1, OK, 0, 0,            -1, 0));
    vecs.push_back(mk(1, NS, 16'h04, SH, 1, 32'h00AA0000, P3, 1, OK, 0, 0,             1, 32'h11223344));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'h0000BEEF, P3, 1, OK, 0, 0,             1, 32'h11AA3344));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'h0,        P3, 1, OK, 0, 0,             1, 32'h11AABEEF));
    vecs.push_back(mk(1, NS, 16'h20, SW, 0, 32'h0,        P3, 1, OK, 1, 32'hDEADBEEF, -1, 0));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'h0,        P3, 0, ER, 1, 32'hDEADBEEF, -1, 0));
    vecs.push_back(mk(1, NS, 16'h01, SH, 1, 32'h0,        P3, 1, ER, 0, 0,            -1, 0));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'hFFFFFFFF, P3, 0, ER, 0, 0,             0, 32'h0));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'h0,        P3, 1, ER, 1, 32'hDEADBEEF,  0, 32'h0));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'h0,        P3, 1, OK, 0, 0,             1, 32'h11AABEEF));
    vecs.push_back(mk(0, NS, 16'h08, SW, 1, 32'h0,        P3, 1, OK, 0, 0,            -1, 0));
    vecs.push_back(mk(1, BZ, 16'h08, SW, 1, 32'h55555555, P3, 1, OK, 0, 0,             2, 32'h0));
    vecs.push_back(mk(1, ID, 16'h08, SW, 1, 32'h55555555, P3, 1, OK, 0, 0,             2, 32'h0));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'h0,        P3, 1, OK, 1, 32'hDEADBEEF,  2, 32'h0));
    vecs.push_back(mk(1, NS, 16'h08, SW, 1, 32'h0,        P3, 1, OK, 0, 0,            -1, 0));
    vecs.push_back(mk(1, SQ, 16'h0C, SW, 1, 32'hCAFEF00D, P3, 1, OK, 0, 0,            -1, 0));
    vecs.push_back(mk(1, NS, 16'h08, SW, 0, 32'h12345678, P3, 1, OK, 0, 0,             2, 32'hCAFEF00D));
    vecs.push_back(mk(1, NS, 16'h0C, SW, 0, 32'h0,        P3, 1, OK, 1, 32'hCAFEF00D,  3, 32'h12345678));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'h0,        P3, 1, OK, 1, 32'h12345678, -1, 0));
    vecs.push_back(mk(1, NS, 16'h00, 3'b011, 0, 32'h0,    P3, 1, OK, 0, 0,            -1, 0));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'h0,        P3, 0, ER, 1, 32'h12345678, -1, 0));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'h0,        P3, 1, ER, 0, 0,            -1, 0));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'h0,        P3, 1, OK, 1, 32'h12345678, -1, 0));
    vecs.push_back(mk(1, NS, 16'h1C, SW, 0, 32'h0,        P3, 1, OK, 0, 0,            -1, 0));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'h0,        P3, 1, OK, 1, 32'h0,        -1, 0));
    // User-mode write to register 0, then a privileged one.
    vecs.push_back(mk(1, NS, 16'h00, SW, 1, 32'h0,        P1, 1, OK, 0, 0,            -1, 0));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'hA5,       P1, !PROT, PROT ? ER : OK, 0, 0, -1, 0));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'h0,        P1, 1, PROT ? ER : OK, 0, 0,  0, PROT ? 32'h0 : 32'hA5));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'h0,        P3, 1, OK, 0, 0,             0, PROT ? 32'h0 : 32'hA5));
    vecs.push_back(mk(1, NS, 16'h00, SW, 1, 32'h0,        P3, 1, OK, 0, 0,            -1, 0));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'h5A,       P3, 1, OK, 0, 0,            -1, 0));
    vecs.push_back(mk(1, ID, 16'h00, SW, 0, 32'h0,        P3, 1, OK, 0, 0,             0, 32'h5A));

    repeat (2) @(negedge HCLK);
    #1;
    check("rst_rdy0",  32'(HREADY0), 32'h1);
    check("rst_resp0", 32'(HRESP0),  32'h0);
    check("rst_rd0",   HRDATA0,      32'h0);
    check("rst_rdy3",  32'(HREADY3), 32'h1);
    check("rst_reg0",  REG_OUT0[31:0],    32'h0);
    check("rst_reg7",  REG_OUT0[255:224], 32'h0);
    @(negedge HCLK);
    H_REST = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge HCLK);
      sel0 = vecs[i].sel; S_HTRANS = vecs[i].trans; S_HADDR = {16'h0, vecs[i].addr};
      S_HSIZE = vecs[i].size; S_HWRITE = vecs[i].wr; S_HWDATA = vecs[i].wdata;
      S_HPORT = vecs[i].port;
      #1;
      check($sformatf("row%0d_rdy", i),  32'(HREADY0), 32'(vecs[i].exp_rdy));
      check($sformatf("row%0d_resp", i), 32'(HRESP0),  32'(vecs[i].exp_resp));
      if (vecs[i].chk_rd)
        check($sformatf("row%0d_rdata", i), HRDATA0, vecs[i].exp_rd);
      if (vecs[i].reg_idx >= 0)
        check($sformatf("row%0d_reg%0d", i, vecs[i].reg_idx),
              REG_OUT0[32*vecs[i].reg_idx +: 32], vecs[i].exp_reg);
    end

    // Three-wait instance: write reg2, then read it back.
    @(negedge HCLK);
    sel0 = 1'b0; sel3 = 1'b1; S_HPORT = P3;
    S_HTRANS = NS; S_HADDR = 32'h8; S_HSIZE = SW; S_HWRITE = 1'b1;
    #1;
    check("w3_wr_addr_rdy", 32'(HREADY3), 32'h1);
    S_HWDATA = 32'h0BADCAFE;
    count_wait(n);
    check("w3_wr_waits", 32'(n), 32'd3);
    check("w3_wr_resp",  32'(HRESP3), 32'h0);

    @(negedge HCLK);
    S_HTRANS = NS; S_HADDR = 32'h8; S_HWRITE = 1'b0; S_HWDATA = 32'h0;
    #1;
    check("w3_rd_addr_rdy", 32'(HREADY3), 32'h1);
    check("w3_reg2", REG_OUT3[95:64], 32'h0BADCAFE);
    count_wait(n);
    check("w3_rd_waits", 32'(n), 32'd3);
    check("w3_rd_resp",  32'(HRESP3), 32'h0);
    check("w3_rd_data",  HRDATA3, 32'h0BADCAFE);

    // Reset pulsed during the wait states of a write to reg3.
    @(negedge HCLK);
    S_HTRANS = NS; S_HADDR = 32'hC; S_HWRITE = 1'b1;
    @(negedge HCLK);
    S_HTRANS = ID; S_HWDATA = 32'hFFFFFFFF;
    #1;
    check("w3_rst_in_wait", 32'(HREADY3), 32'h0);
    H_REST = 1'b1;
    #1;
    check("w3_rst_rdy",  32'(HREADY3), 32'h1);
    check("w3_rst_resp", 32'(HRESP3),  32'h0);
    check("w3_rst_rd",   HRDATA3,      32'h0);
    check("w3_rst_reg2", REG_OUT3[95:64], 32'h0);
    @(negedge HCLK);
    H_REST = 1'b0;
    repeat (5) @(negedge HCLK);
    #1;
    check("w3_post_rst_reg3", REG_OUT3[127:96], 32'h0);
    check("w3_post_rst_rdy",  32'(HREADY3), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_reg_slave.md
Name: ahb_reg_slave

Overview:
- AHB-Lite responder (slave end) that attaches to one Sx_* port group of the AHB interconnect. It decodes the shared S_* bus plus its own HSEL.
- Implements a bank of 32-bit control/status registers with configurable wait states, byte-lane writes, an ERROR response for bad accesses, and back-to-back pipelined transfers.
- Register contents are exported as a flat bus for peripheral logic.

Parameters:
- REG_NUM, 8, number of 32-bit registers; word offsets 0..REG_NUM-1 (byte offsets 0..4*REG_NUM-4).
- WAIT_CYCLES, 0, wait states inserted per data phase (0..15).
- C_S_AHB_DATA_WIDTH, 32, data width (fixed at 32).
- C_S_AHB_ADDR_WIDTH, 32, address width.

Ports:
- HCLK  in  1  system clock.
- H_REST  in  1  reset, asynchronous, active-high.
- HSEL  in  1  slave select from interconnect.
- S_HADDR  in  C_S_AHB_ADDR_WIDTH  offset address (already masked to 16 bits).
- S_HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- S_HBURST  in  3  burst type (ignored; every beat handled independently).
- S_HSIZE  in  3  000 byte, 001 half, 010 word.
- S_HPORT  in  4  protection (used only with the optional feature).
- S_HWRITE  in  1  1 = write.
- S_HWDATA  in  32  write data (data phase).
- HRDATA  out  32  read data.
- HRESP  out  2  00 OKAY, 01 ERROR.
- HREADY_o  out  1  1 = data phase completes this cycle.
- REG_OUT  out  32*REG_NUM  register contents; reg k occupies bits [32k+31:32k].

Behaviour:
- Reset (async, H_REST=1):
  - Registers = 0, HRDATA = 0, HRESP = 00, HREADY_o = 1.
  - FSM enters IDLE, wait counter = 0.
  - Reset asserted mid-transfer aborts the transfer; no register write occurs.
- Address sample: the transfer is accepted on a rising edge where HSEL=1, S_HTRANS[1]=1 and HREADY_o=1. Latch address, size and write.
- Unselected, IDLE or BUSY transfers get a zero-wait OKAY response; HREADY_o remains 1.
- Bad access (goes to error) if either holds:
  - word offset >= REG_NUM, or S_HSIZE > 010;
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=00.
- FSM states:
  - IDLE: HREADY_o=1, HRESP=00. Accepted good transfer -> WAIT if WAIT_CYCLES>0, else DATA. Accepted bad transfer -> ERR1.
  - WAIT: HREADY_o=0, HRESP=00. Counter counts 0..WAIT_CYCLES-1, then -> DATA.
  - DATA: HREADY_o=1, HRESP=00; the transfer completes this cycle. A new accepted transfer at this edge -> WAIT/DATA/ERR1; otherwise -> IDLE.
  - ERR1: HREADY_o=0, HRESP=01 -> ERR2.
  - ERR2: HREADY_o=1, HRESP=01. A new accepted transfer at this edge follows the same rules as in DATA. An errored write never modifies registers.
- Reads: HRDATA is loaded from the addressed register on the edge entering DATA, so it is valid throughout the DATA cycle. HRDATA holds its last value at all other times (ERROR included). Latency from address phase to data = 1 + WAIT_CYCLES cycles.
- Writes: S_HWDATA is committed on the edge ending DATA.
  - Byte strobes come from size/addr[1:0]:
    - byte: 1 << addr[1:0];
    - half: 0011 << addr[1:0];
    - word: 1111.
  - Only strobed lanes update.
- Read-after-write hazard (WAIT_CYCLES=0, write data phase overlapping a read address phase to the same word): HRDATA gets the committing write merged per byte strobe (forwarding). It never returns stale data.
- Simultaneous write commit and new write address: both are handled; the commit uses the previously latched address.

Optional Feature:
- Macro: AHB_REG_SLAVE_PROT_EN.
- Defined: a write with S_HPORT[1]=0 (user access) to word offset 0 (config register) is a bad access and receives the two-cycle ERROR; reads are unaffected.
- Undefined: S_HPORT is ignored entirely.

Decomposition:
- Shared package ahb_pkg: HTRANS codes, HRESP codes (OKAY/ERROR), HSIZE codes, FSM state encoding, byte-strobe function.
- One sub-module, ahb_reg_bank: register array with byte-strobe write port, combinational read port, and forwarding merge. The top holds the FSM, wait counter and decode.

Test Plan:
- Reset, then NONSEQ word write 0xDEADBEEF to 0x0004 followed by a read of 0x0004 (WAIT_CYCLES=0) -> HREADY_o stays 1, forwarded HRDATA=0xDEADBEEF, REG_OUT[63:32]=0xDEADBEEF.
- WAIT_CYCLES=3, word read of 0x0008 -> HREADY_o low exactly 3 cycles, then 1 with HRDATA = reg2, HRESP=00.
- Byte write 0xAA to 0x0006 over reg1=0x11223344 -> reg1=0x11AA3344; half write 0xBEEF to 0x0004 -> reg1=0x11AABEEF.
- Read of 0x0020 (REG_NUM=8) and half write to 0x0001 -> each gives ERR1 (HREADY_o=0, HRESP=01) then ERR2 (HREADY_o=1, HRESP=01); registers unchanged.
- HSEL=0 or HTRANS=IDLE/BUSY with valid address -> HREADY_o=1, HRESP=00, no state change; H_REST pulsed during WAIT of a write -> outputs at reset values, register not written.
- AHB_REG_SLAVE_PROT_EN defined: write to 0x0000 with HPORT=4'b0001 -> ERROR, reg0 unchanged; same write with HPORT=4'b0011 -> OKAY, reg0 written.
